ysyx_22040365_regfile_mp: RTL and testbench

Parametrised multi-port integer register file fused with the ID/EX pipeline register. It takes NRD read requests from the IF/ID stage and registers the operand data, addresses and an opaque pipeline payload into the EX stage with one cycle of latency. Up to NWR writebacks per cycle are accepted, and same-cycle writes are bypassed into the reads. Unlike the single-write generation, it supports flush/bubble insertion and keeps held operands coherent with writebacks that land during a stall.

---
 rtl/ysyx_22040365_regfile_mp_pkg.sv | 36 +++
 rtl/ysyx_22040365_regfile_mp_wr_arb.sv | 42 ++++
 rtl/ysyx_22040365_regfile_mp.sv | 177 +++++++++++++++++
 tb/tb_ysyx_22040365_regfile_mp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040365_regfile_mp_pkg.sv
// ============================================================================
// Module      : ysyx_22040365_defines (package)
// Description : Shared word width, zero constant, ID/EX payload field map and
//               the ID/EX update-mode encoding used by the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22040365_defines;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    // Bit offsets and widths of the fields packed into the opaque payload
    localparam int PL_RD_OFF     = 0;
    localparam int PL_RD_W       = 5;
    localparam int PL_IMM_OFF    = PL_RD_OFF + PL_RD_W;
    localparam int PL_IMM_W      = 64;
    localparam int PL_PC_OFF     = PL_IMM_OFF + PL_IMM_W;
    localparam int PL_PC_W       = 64;
    localparam int PL_INST_OFF   = PL_PC_OFF + PL_PC_W;
    localparam int PL_INST_W     = 32;
    localparam int PL_OPCODE_OFF = PL_INST_OFF + PL_INST_W;
    localparam int PL_OPCODE_W   = 8;
    localparam int PL_TYPE_OFF   = PL_OPCODE_OFF + PL_OPCODE_W;
    localparam int PL_TYPE_W     = 8;

    typedef enum logic [1:0] {
        UPD_LOAD  = 2'd0,
        UPD_STALL = 2'd1,
        UPD_FLUSH = 2'd2
    } upd_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040365_regfile_mp_wr_arb.sv
// ============================================================================
// Module      : ysyx_22040365_wr_arb
// Description : Combinational write-port arbiter for one query address;
//               reports a hit and the data of the highest-index matching port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040365_wr_arb #(
    parameter int XLEN     = 64,
    parameter int AW       = 5,
    parameter int NREGS    = 32,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic [AW-1:0]       i_q_addr,
    output logic                o_hit,
    output logic [XLEN-1:0]     o_data
);

    logic w_q_ok;

    // Addresses that can never hold state (hardwired zero, out of range) never hit
    assign w_q_ok = (32'(i_q_addr) < 32'(NREGS)) && !((ZERO_REG != 0) && (i_q_addr == '0));

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < NWR; k++) begin
            if (w_q_ok && i_wr_en[k] && (i_wr_addr[k*AW +: AW] == i_q_addr)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040365_regfile_mp.sv
// ============================================================================
// Module      : ysyx_22040365_regfile_mp
// Description : Multi-port register file fused with the ID/EX register, with
//               write-first bypass, flush/bubble insertion and stall refresh.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040365_regfile_mp #(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter int AW        = 5,
    parameter int NRD       = 2,
    parameter int NWR       = 1,
    parameter int PAYLOAD_W = 256,
    parameter int ZERO_REG  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  valid_i,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AW-1:0]     rd_addr,
    input  logic [PAYLOAD_W-1:0]  payload_i,
    output logic                  valid_q,
    output logic [NRD-1:0]        rd_en_q,
    output logic [NRD*AW-1:0]     rd_addr_q,
    output logic [NRD*XLEN-1:0]   rd_data_q,
    output logic [PAYLOAD_W-1:0]  payload_q,
    output logic [NREGS*XLEN-1:0] regs_o
);

    import ysyx_22040365_defines::*;

    logic [XLEN-1:0]      regs_q [NREGS];
    logic [XLEN-1:0]      regs_d [NREGS];
    logic                 valid_d;
    logic [NRD-1:0]       rd_en_d;
    logic [NRD*AW-1:0]    rd_addr_d;
    logic [NRD*XLEN-1:0]  rd_data_d;
    logic [PAYLOAD_W-1:0] payload_d;

    logic [NRD-1:0]       w_rd_hit;
    logic [XLEN-1:0]      w_rd_wdata   [NRD];
    logic [NRD-1:0]       w_hold_hit;
    logic [XLEN-1:0]      w_hold_wdata [NRD];
    logic [NRD*XLEN-1:0]  w_rd_eff;
    logic [NREGS-1:0]     w_reg_hit;
    logic [XLEN-1:0]      w_reg_wdata  [NREGS];
    upd_e                 w_upd;

    // One arbiter on the incoming address, one on the held address for refresh
    for (genvar j = 0; j < NRD; j++) begin : g_rd_arb
        ysyx_22040365_wr_arb #(
            .XLEN(XLEN), .AW(AW), .NREGS(NREGS), .NWR(NWR), .ZERO_REG(ZERO_REG)
        ) u_rd_arb (
            .i_wr_en  (wr_en),
            .i_wr_addr(wr_addr),
            .i_wr_data(wr_data),
            .i_q_addr (rd_addr[j*AW +: AW]),
            .o_hit    (w_rd_hit[j]),
            .o_data   (w_rd_wdata[j])
        );

        ysyx_22040365_wr_arb #(
            .XLEN(XLEN), .AW(AW), .NREGS(NREGS), .NWR(NWR), .ZERO_REG(ZERO_REG)
        ) u_hold_arb (
            .i_wr_en  (wr_en),
            .i_wr_addr(wr_addr),
            .i_wr_data(wr_data),
            .i_q_addr (rd_addr_q[j*AW +: AW]),
            .o_hit    (w_hold_hit[j]),
            .o_data   (w_hold_wdata[j])
        );
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        ysyx_22040365_wr_arb #(
            .XLEN(XLEN), .AW(AW), .NREGS(NREGS), .NWR(NWR), .ZERO_REG(ZERO_REG)
        ) u_reg_arb (
            .i_wr_en  (wr_en),
            .i_wr_addr(wr_addr),
            .i_wr_data(wr_data),
            .i_q_addr (AW'(i)),
            .o_hit    (w_reg_hit[i]),
            .o_data   (w_reg_wdata[i])
        );

        assign regs_d[i] = w_reg_hit[i] ? w_reg_wdata[i] : regs_q[i];
        assign regs_o[i*XLEN +: XLEN] = ((ZERO_REG != 0) && (i == 0)) ? ZERO_WORD : regs_d[i];
    end

    always_comb begin
        w_rd_eff = '0;
        for (int j = 0; j < NRD; j++) begin
            if (!rd_en[j] || (32'(rd_addr[j*AW +: AW]) >= 32'(NREGS)) ||
                ((ZERO_REG != 0) && (rd_addr[j*AW +: AW] == '0))) begin
                w_rd_eff[j*XLEN +: XLEN] = ZERO_WORD;
            end else if (w_rd_hit[j]) begin
                w_rd_eff[j*XLEN +: XLEN] = w_rd_wdata[j];
            end else begin
                w_rd_eff[j*XLEN +: XLEN] = regs_q[rd_addr[j*AW +: AW]];
            end
        end
    end

    always_comb begin
        if (flush) begin
            w_upd = UPD_FLUSH;
        end else if (stall) begin
            w_upd = UPD_STALL;
        end else begin
            w_upd = UPD_LOAD;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        payload_d = payload_q;
        case (w_upd)
            UPD_FLUSH: begin
                valid_d   = 1'b0;
                rd_en_d   = '0;
                rd_addr_d = '0;
                rd_data_d = '0;
                payload_d = '0;
            end
            UPD_STALL: begin
                // Held operands track writebacks landing while the stage is frozen
                for (int j = 0; j < NRD; j++) begin
                    if (rd_en_q[j] && w_hold_hit[j]) begin
                        rd_data_d[j*XLEN +: XLEN] = w_hold_wdata[j];
                    end
                end
            end
            default: begin
                valid_d   = valid_i;
                rd_en_d   = rd_en;
                rd_addr_d = rd_addr;
                rd_data_d = w_rd_eff;
                payload_d = payload_i;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rd_en_q   <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            payload_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= ZERO_WORD;
            end
        end else begin
            valid_q   <= valid_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            payload_q <= payload_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040365_regfile_mp.sv
// ============================================================================
// Module      : tb_ysyx_22040365_regfile_mp
// Description : Self-checking bench: directed vector table plus random traffic
//               compared against an array-based register file model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_22040365_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int PW    = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, stall, flush, valid_i;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*XLEN-1:0]   wr_data;
    logic [NRD-1:0]        rd_en;
    logic [NRD*AW-1:0]     rd_addr;
    logic [PW-1:0]         payload_i;

    logic                  valid_q_a, valid_q_b;
    logic [NRD-1:0]        rd_en_q_a, rd_en_q_b;
    logic [NRD*AW-1:0]     rd_addr_q_a, rd_addr_q_b;
    logic [NRD*XLEN-1:0]   rd_data_q_a, rd_data_q_b;
    logic [PW-1:0]         payload_q_a, payload_q_b;
    logic [NREGS*XLEN-1:0] regs_o_a, regs_o_b;

    ysyx_22040365_regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR),
        .PAYLOAD_W(PW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .valid_i(valid_i), .rd_en(rd_en), .rd_addr(rd_addr), .payload_i(payload_i),
        .valid_q(valid_q_a), .rd_en_q(rd_en_q_a), .rd_addr_q(rd_addr_q_a),
        .rd_data_q(rd_data_q_a), .payload_q(payload_q_a), .regs_o(regs_o_a)
    );

    ysyx_22040365_regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR),
        .PAYLOAD_W(PW), .ZERO_REG(0)
    ) dut_z0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .valid_i(valid_i), .rd_en(rd_en), .rd_addr(rd_addr), .payload_i(payload_i),
        .valid_q(valid_q_b), .rd_en_q(rd_en_q_b), .rd_addr_q(rd_addr_q_b),
        .rd_data_q(rd_data_q_b), .payload_q(payload_q_b), .regs_o(regs_o_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the ZERO_REG=1 instance
    logic [63:0]  m_regs [32];
    logic         m_valid;
    logic [1:0]   m_rd_en;
    logic [4:0]   m_addr [2];
    logic [63:0]  m_data [2];
    logic [255:0] m_pay;

    task automatic chk(input string tag, input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %h expected %h", tag, nm, act, exp);
        end
    endtask

    // Last enabled port writing address a wins; x0 never written
    function automatic void last_write(input logic [4:0] a, output logic h, output logic [63:0] v);
        h = 1'b0;
        v = '0;
        if (a != 5'd0) begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k] && wr_addr[k*5 +: 5] == a) begin
                    h = 1'b1;
                    v = wr_data[k*64 +: 64];
                end
            end
        end
    endfunction

    function automatic logic [63:0] exp_reg(input int i);
        logic h;
        logic [63:0] v;
        last_write(5'(i), h, v);
        return h ? v : m_regs[i];
    endfunction

    task automatic model_step();
        logic [63:0] rdv [2];
        logic [63:0] nregs [32];
        logic        h;
        logic [63:0] v;
        logic [4:0]  a;
        for (int j = 0; j < 2; j++) begin
            a = rd_addr[j*5 +: 5];
            last_write(a, h, v);
            if (!rd_en[j] || a == 5'd0) rdv[j] = '0;
            else if (h)                 rdv[j] = v;
            else                        rdv[j] = m_regs[a];
        end
        for (int i = 0; i < 32; i++) nregs[i] = exp_reg(i);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_valid = 1'b0; m_rd_en = '0; m_pay = '0;
            for (int j = 0; j < 2; j++) begin m_addr[j] = '0; m_data[j] = '0; end
        end else begin
            for (int i = 0; i < 32; i++) m_regs[i] = nregs[i];
            if (flush) begin
                m_valid = 1'b0; m_rd_en = '0; m_pay = '0;
                for (int j = 0; j < 2; j++) begin m_addr[j] = '0; m_data[j] = '0; end
            end else if (stall) begin
                for (int j = 0; j < 2; j++) begin
                    last_write(m_addr[j], h, v);
                    if (m_rd_en[j] && h) m_data[j] = v;
                end
            end else begin
                m_valid = valid_i; m_rd_en = rd_en; m_pay = payload_i;
                for (int j = 0; j < 2; j++) begin
                    m_addr[j] = rd_addr[j*5 +: 5];
                    m_data[j] = rdv[j];
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        int bad;
        bad = -1;
        chk(tag, "valid_q",   256'(valid_q_a),   256'(m_valid));
        chk(tag, "rd_en_q",   256'(rd_en_q_a),   256'(m_rd_en));
        chk(tag, "rd_addr_q", 256'(rd_addr_q_a), 256'({m_addr[1], m_addr[0]}));
        chk(tag, "rd_data_q", 256'(rd_data_q_a), 256'({m_data[1], m_data[0]}));
        chk(tag, "payload_q", payload_q_a,       m_pay);
        for (int i = 0; i < 32; i++)
            if (bad < 0 && regs_o_a[i*64 +: 64] !== exp_reg(i)) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL [%s] regs_o[%0d]: got %h expected %h", tag, bad, regs_o_a[bad*64 +: 64], exp_reg(bad));
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic rst, stall, flush, valid;
        logic [1:0] we; logic [4:0] wa0; logic [63:0] wd0; logic [4:0] wa1; logic [63:0] wd1;
        logic [1:0] re; logic [4:0] ra0; logic [4:0] ra1; logic [255:0] pay;
        logic ev; logic [63:0] ed0; logic [63:0] ed1; logic [63:0] ez0; logic [255:0] epay;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic s, input logic f, input logic vl,
        input logic [1:0] we, input logic [4:0] wa0, input logic [63:0] wd0,
        input logic [4:0] wa1, input logic [63:0] wd1,
        input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1, input logic [255:0] pay,
        input logic ev, input logic [63:0] ed0, input logic [63:0] ed1, input logic [63:0] ez0,
        input logic [255:0] epay);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.valid = vl;
        t.we = we; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
        t.re = re; t.ra0 = ra0; t.ra1 = ra1; t.pay = pay;
        t.ev = ev; t.ed0 = ed0; t.ed1 = ed1; t.ez0 = ez0; t.epay = epay;
        return t;
    endfunction

    vec_t tv [17];

    initial begin
        logic [255:0] ones;
        string tag;
        ones = '1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 0; m_rd_en = 0; m_pay = 0;
        for (int j = 0; j < 2; j++) begin m_addr[j] = 0; m_data[j] = 0; end

        //              rst s f v  we     wa0 wd0       wa1 wd1       re     ra0 ra1 pay     ev ed0       ed1       ez0       epay
        tv[0]  = mk(1, 0, 0, 1, 2'b01, 5, 64'h99,    0, 0,         2'b11, 5,  0, 256'h1, 0, 0,        0,        0,        0);
        tv[1]  = mk(0, 0, 0, 1, 2'b11, 5, 64'h1234,  5, 64'hABCD,  2'b00, 0,  0, 256'h1, 1, 0,        0,        0,        256'h1);
        tv[2]  = mk(0, 0, 0, 1, 2'b00, 0, 0,         0, 0,         2'b01, 5,  0, 256'h2, 1, 64'hABCD, 0,        64'hABCD, 256'h2);
        tv[3]  = mk(0, 0, 0, 1, 2'b01, 3, 64'hDEAD,  0, 0,         2'b11, 3,  5, 256'h3, 1, 64'hDEAD, 64'hABCD, 64'hDEAD, 256'h3);
        tv[4]  = mk(0, 0, 0, 0, 2'b01, 7, 64'h11,    0, 0,         2'b00, 0,  0, 256'h0, 0, 0,        0,        0,        0);
        tv[5]  = mk(0, 0, 0, 1, 2'b00, 0, 0,         0, 0,         2'b01, 7,  0, 256'hA5,1, 64'h11,   0,        64'h11,   256'hA5);
        tv[6]  = mk(0, 1, 0, 0, 2'b00, 0, 0,         0, 0,         2'b11, 3,  5, ones,   1, 64'h11,   0,        64'h11,   256'hA5);
        tv[7]  = mk(0, 1, 0, 0, 2'b10, 0, 0,         7, 64'h22,    2'b11, 3,  5, ones,   1, 64'h22,   0,        64'h22,   256'hA5);
        tv[8]  = mk(0, 1, 0, 0, 2'b00, 0, 0,         0, 0,         2'b11, 3,  5, ones,   1, 64'h22,   0,        64'h22,   256'hA5);
        tv[9]  = mk(0, 0, 0, 1, 2'b00, 0, 0,         0, 0,         2'b01, 7,  0, 256'hB, 1, 64'h22,   0,        64'h22,   256'hB);
        tv[10] = mk(0, 1, 1, 1, 2'b01, 9, 64'h55,    0, 0,         2'b11, 5,  3, ones,   0, 0,        0,        0,        0);
        tv[11] = mk(0, 0, 0, 1, 2'b00, 0, 0,         0, 0,         2'b10, 0,  9, 256'hC, 1, 0,        64'h55,   0,        256'hC);
        tv[12] = mk(0, 0, 0, 1, 2'b01, 0, 64'h99,    0, 0,         2'b01, 0,  0, 256'hD, 1, 0,        0,        64'h99,   256'hD);
        tv[13] = mk(0, 0, 0, 1, 2'b00, 0, 0,         0, 0,         2'b01, 5,  0, 256'h7, 1, 64'hABCD, 0,        64'hABCD, 256'h7);
        tv[14] = mk(0, 1, 0, 1, 2'b01, 5, 64'h77,    0, 0,         2'b01, 5,  0, 256'h8, 1, 64'h77,   0,        64'h77,   256'h7);
        tv[15] = mk(1, 1, 0, 1, 2'b11, 5, 64'h88,    6, 64'h66,    2'b11, 5,  6, 256'h9, 0, 0,        0,        0,        0);
        tv[16] = mk(0, 0, 0, 1, 2'b00, 0, 0,         0, 0,         2'b11, 5,  6, 256'hE, 1, 0,        0,        0,        256'hE);

        for (int i = 0; i < 17; i++) begin
            tag = $sformatf("vec%0d", i);
            rst = tv[i].rst; stall = tv[i].stall; flush = tv[i].flush; valid_i = tv[i].valid;
            wr_en = tv[i].we; wr_addr = {tv[i].wa1, tv[i].wa0}; wr_data = {tv[i].wd1, tv[i].wd0};
            rd_en = tv[i].re; rd_addr = {tv[i].ra1, tv[i].ra0}; payload_i = tv[i].pay;
            tick(tag);
            chk(tag, "tbl valid_q",   256'(valid_q_a),            256'(tv[i].ev));
            chk(tag, "tbl rd_data0",  256'(rd_data_q_a[63:0]),    256'(tv[i].ed0));
            chk(tag, "tbl rd_data1",  256'(rd_data_q_a[127:64]),  256'(tv[i].ed1));
            chk(tag, "tbl payload_q", payload_q_a,                tv[i].epay);
            chk(tag, "z0 rd_data0",   256'(rd_data_q_b[63:0]),    256'(tv[i].ez0));
            if (i == 12) begin
                chk(tag, "regs_o[0] zr1", 256'(regs_o_a[63:0]), 256'(0));
                chk(tag, "regs_o[0] zr0", 256'(regs_o_b[63:0]), 256'(64'h99));
            end
            if (i == 15) begin
                wr_en = '0;
                #1;
                chk(tag, "post-rst regs_o zr1", 256'(regs_o_a != '0), 256'(0));
                chk(tag, "post-rst regs_o zr0", 256'(regs_o_b != '0), 256'(0));
                chk(tag, "post-rst z0 valid_q", 256'(valid_q_b), 256'(0));
            end
        end

        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            valid_i = 1'($urandom);
            wr_en = 2'($urandom);
            rd_en = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                wr_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                rd_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                wr_data[k*64 +: 64] = {$urandom, $urandom};
            end
            payload_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
